mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//   Shares one single-ported memory between instruction fetch (IF) and the MEM-stage
//   load/store path (driven by the decoded MemRead/MemWrite controls).
//   - One transaction outstanding at a time.
//   - Fixed priority to the data port, with a starvation guard for fetch.
//   - Sits between the pipeline front/back ends and the unified memory.
// PARAMETERS
//   AW             32  address width
//   DW             32  data width; must be a multiple of 8
//   MAX_DM_STREAK  4   max consecutive data grants while IF waits (>=1)
// PORTS
//   clk        in   1       clock, rising edge
//   rst_n      in   1       asynchronous active-low reset
//   if_req     in   1       fetch read request; level, held until if_gnt
//   if_addr    in   AW      fetch address; stable while if_req && !if_gnt
//   if_gnt     out  1       1-cycle pulse: fetch request accepted
//   if_rvalid  out  1       1-cycle pulse: fetch data valid
//   if_rdata   out  DW      fetch data
//   dm_req     in   1       data request; level, held until dm_gnt
//   dm_we      in   1       1 = store, 0 = load
//   dm_addr    in   AW      data address
//   dm_wdata   in   DW      store data
//   dm_wstrb   in   DW/8    store byte enables
//   dm_gnt     out  1       1-cycle pulse: data request accepted
//   dm_rvalid  out  1       1-cycle pulse: load data valid, or store complete
//   dm_rdata   out  DW      load data; 0 for stores
//   mem_req    out  1       memory command valid
//   mem_we     out  1       memory write enable
//   mem_addr   out  AW      memory address
//   mem_wdata  out  DW      memory write data
//   mem_wstrb  out  DW/8    memory byte enables; 0 for reads
//   mem_gnt    in   1       memory accepts the command this cycle
//   mem_rvalid in   1       memory response (read data or write ack)
//   mem_rdata  in   DW      memory read data
//   err_spur   out  1       sticky: mem_rvalid seen outside RESP
// BEHAVIOUR
//   Reset (async, rst_n=0):
//   - All outputs 0; state IDLE; streak counter 0.
//   - Any in-flight transaction is abandoned; no gnt/rvalid is issued for it.
//   FSM: IDLE -> REQ -> RESP -> IDLE.
//   - IDLE: arbitration when if_req|dm_req.
//     - Winner is dm, unless if_req && dm_req && streak==MAX_DM_STREAK, then IF wins.
//     - At the next edge: latch the winner's command into mem_*, set mem_req=1,
//       pulse the winner's gnt, record owner, go to REQ.
//     - IF commands set mem_we=0 and mem_wstrb=0.
//   - REQ: hold mem_* stable until mem_gnt=1; at that edge mem_req=0, go to RESP.
//   - RESP: on mem_rvalid, at the next edge pulse the owner's rvalid, register
//     rdata (dm_rdata=0 when owner's op was a store), go to IDLE.
//     - No arbitration in the same cycle; the next grant is earliest 1 cycle after rvalid.
//   Latency: req seen at cycle 0 -> gnt + mem_req at cycle 1. With mem_gnt at
//     cycle 1 and mem_rvalid at cycle 2, requester rvalid is at cycle 3.
//   Streak counter, updated only on grant:
//   - dm grant with if_req=1: streak+1, saturating at MAX_DM_STREAK.
//   - dm grant with if_req=0: streak=0.
//   - IF grant: streak=0.
//   Requests:
//   - A requester dropping req before gnt is simply not served.
//   - Requests arriving in REQ/RESP wait; they are not queued beyond their level.
//   - if_rdata and dm_rdata hold their last value between rvalid pulses.
//   - mem_rvalid in IDLE or REQ is ignored and sets err_spur; err_spur clears only on reset.
//   Width rules: no arithmetic on addresses/data; the counter is $clog2(MAX_DM_STREAK+1) bits.
// TESTING
//   1 Only if_req, addr=0x100; mem_gnt immediately; mem_rvalid 1 cycle later, rdata=0xDEADBEEF
//     -> if_gnt@1, mem_req@1, if_rvalid@3 with 0xDEADBEEF; dm_* stay 0.
//   2 if_req and dm_req both high, dm_we=1, addr=0x200, wstrb=0xF, mem_gnt delayed 3 cycles
//     -> dm_gnt first; mem_* held stable 3 cycles; dm_rvalid with dm_rdata=0;
//        the IF grant follows.
//   3 if_req held high, dm_req re-asserted after each dm_gnt, MAX_DM_STREAK=4
//     -> exactly 4 dm grants, then 1 IF grant, then dm resumes.
//   4 rst_n pulsed low while in RESP
//     -> all outputs 0 immediately; a later mem_rvalid produces no rvalid and sets err_spur.
//   5 mem_rvalid asserted while IDLE -> err_spur=1 and stays 1 until reset; no rvalid pulses.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester-side (IF, data) and memory-side signals around the
// shared-memory port arbiter. The arbiter uses the slave view; the
// surrounding pipeline/memory environment uses the master view.
interface mem_port_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32
) ();
   // instruction fetch port
   logic            if_req;
   logic [AW-1:0]   if_addr;
   logic            if_gnt;
   logic            if_rvalid;
   logic [DW-1:0]   if_rdata;
   // data (load/store) port
   logic            dm_req;
   logic            dm_we;
   logic [AW-1:0]   dm_addr;
   logic [DW-1:0]   dm_wdata;
   logic [DW/8-1:0] dm_wstrb;
   logic            dm_gnt;
   logic            dm_rvalid;
   logic [DW-1:0]   dm_rdata;
   // unified memory port
   logic            mem_req;
   logic            mem_we;
   logic [AW-1:0]   mem_addr;
   logic [DW-1:0]   mem_wdata;
   logic [DW/8-1:0] mem_wstrb;
   logic            mem_gnt;
   logic            mem_rvalid;
   logic [DW-1:0]   mem_rdata;
   // status
   logic            err_spur;

   modport slave (
      input  if_req, if_addr,
      output if_gnt, if_rvalid, if_rdata,
      input  dm_req, dm_we, dm_addr, dm_wdata, dm_wstrb,
      output dm_gnt, dm_rvalid, dm_rdata,
      output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
      input  mem_gnt, mem_rvalid, mem_rdata,
      output err_spur
   );

   modport master (
      output if_req, if_addr,
      input  if_gnt, if_rvalid, if_rdata,
      output dm_req, dm_we, dm_addr, dm_wdata, dm_wstrb,
      input  dm_gnt, dm_rvalid, dm_rdata,
      input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
      output mem_gnt, mem_rvalid, mem_rdata,
      input  err_spur
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and the
// MEM-stage load/store path. One transaction in flight; the data port has
// fixed priority, bounded by a streak counter so a waiting fetch is served
// after MAX_DM_STREAK consecutive data grants.
module mem_port_arbiter #(
   parameter int AW            = 32,
   parameter int DW            = 32,
   parameter int MAX_DM_STREAK = 4
) (
   input logic               clk,
   input logic               rst_n,
   mem_port_arbiter_if.slave bus
);
   localparam int SW = $clog2(MAX_DM_STREAK + 1);
   localparam int BW = DW / 8;
   localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DM_STREAK);

   typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RESP} state_t;

   state_t          state_q, state_d;
   logic [SW-1:0]   streak_q, streak_d;
   logic            owner_dm_q, owner_dm_d;
   logic            mem_req_q, mem_req_d;
   logic            mem_we_q, mem_we_d;
   logic [AW-1:0]   mem_addr_q, mem_addr_d;
   logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
   logic [BW-1:0]   mem_wstrb_q, mem_wstrb_d;
   logic            if_gnt_q, if_gnt_d;
   logic            dm_gnt_q, dm_gnt_d;
   logic            if_rvalid_q, if_rvalid_d;
   logic            dm_rvalid_q, dm_rvalid_d;
   logic [DW-1:0]   if_rdata_q, if_rdata_d;
   logic [DW-1:0]   dm_rdata_q, dm_rdata_d;
   logic            err_spur_q, err_spur_d;
   logic            pick_if;

   // state register and all registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         streak_q    <= '0;
         owner_dm_q  <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_wstrb_q <= '0;
         if_gnt_q    <= 1'b0;
         dm_gnt_q    <= 1'b0;
         if_rvalid_q <= 1'b0;
         dm_rvalid_q <= 1'b0;
         if_rdata_q  <= '0;
         dm_rdata_q  <= '0;
         err_spur_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         streak_q    <= streak_d;
         owner_dm_q  <= owner_dm_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_wstrb_q <= mem_wstrb_d;
         if_gnt_q    <= if_gnt_d;
         dm_gnt_q    <= dm_gnt_d;
         if_rvalid_q <= if_rvalid_d;
         dm_rvalid_q <= dm_rvalid_d;
         if_rdata_q  <= if_rdata_d;
         dm_rdata_q  <= dm_rdata_d;
         err_spur_q  <= err_spur_d;
      end
   end

   // arbitration, command latching, response routing and next state
   always_comb begin
      state_d     = state_q;
      streak_d    = streak_q;
      owner_dm_d  = owner_dm_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_wstrb_d = mem_wstrb_q;
      if_gnt_d    = 1'b0;
      dm_gnt_d    = 1'b0;
      if_rvalid_d = 1'b0;
      dm_rvalid_d = 1'b0;
      if_rdata_d  = if_rdata_q;
      dm_rdata_d  = dm_rdata_q;
      err_spur_d  = err_spur_q;
      pick_if     = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (bus.mem_rvalid) err_spur_d = 1'b1;
            if (bus.if_req || bus.dm_req) begin
               pick_if    = bus.if_req && (!bus.dm_req || streak_q == STREAK_MAX);
               state_d    = ST_REQ;
               mem_req_d  = 1'b1;
               owner_dm_d = !pick_if;
               if (pick_if) begin
                  if_gnt_d    = 1'b1;
                  mem_we_d    = 1'b0;
                  mem_addr_d  = bus.if_addr;
                  mem_wdata_d = '0;
                  mem_wstrb_d = '0;
                  streak_d    = '0;
               end else begin
                  dm_gnt_d    = 1'b1;
                  mem_we_d    = bus.dm_we;
                  mem_addr_d  = bus.dm_addr;
                  mem_wdata_d = bus.dm_wdata;
                  mem_wstrb_d = bus.dm_we ? bus.dm_wstrb : '0;
                  if (!bus.if_req)
                     streak_d = '0;
                  else if (streak_q != STREAK_MAX)
                     streak_d = streak_q + SW'(1);
               end
            end
         end
         ST_REQ: begin
            if (bus.mem_rvalid) err_spur_d = 1'b1;
            if (bus.mem_gnt) begin
               mem_req_d = 1'b0;
               state_d   = ST_RESP;
            end
         end
         ST_RESP: begin
            if (bus.mem_rvalid) begin
               state_d = ST_IDLE;
               if (owner_dm_q) begin
                  dm_rvalid_d = 1'b1;
                  dm_rdata_d  = mem_we_q ? '0 : bus.mem_rdata;
               end else begin
                  if_rvalid_d = 1'b1;
                  if_rdata_d  = bus.mem_rdata;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign bus.if_gnt    = if_gnt_q;
   assign bus.if_rvalid = if_rvalid_q;
   assign bus.if_rdata  = if_rdata_q;
   assign bus.dm_gnt    = dm_gnt_q;
   assign bus.dm_rvalid = dm_rvalid_q;
   assign bus.dm_rdata  = dm_rdata_q;
   assign bus.mem_req   = mem_req_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.mem_wstrb = mem_wstrb_q;
   assign bus.err_spur  = err_spur_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by random traffic,
// every cycle checked against a transaction-level model of the arbiter.
module tb_mem_port_arbiter;
   localparam int MAXS = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

   mem_port_arbiter #(.AW(32), .DW(32), .MAX_DM_STREAK(MAXS)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;

   // transaction-level model: phase 0 = free, 1 = waiting mem_gnt, 2 = waiting mem_rvalid
   int          m_phase;
   int          m_streak;
   bit          m_owner_dm;
   bit          m_we;
   logic [31:0] m_addr, m_wdata;
   logic [3:0]  m_wstrb;
   logic [31:0] last_if, last_dm;
   bit          exp_err;

   // memory environment
   logic [31:0] mem_model [16];
   int          r_wait;
   bit          r_we;
   int          r_idx;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      m_phase = 0; m_streak = 0; m_owner_dm = 0; m_we = 0;
      m_addr = '0; m_wdata = '0; m_wstrb = '0;
      last_if = '0; last_dm = '0; exp_err = 0; r_wait = -1;
   endtask

   task automatic drive_idle_inputs();
      bus.if_req = 0; bus.if_addr = '0;
      bus.dm_req = 0; bus.dm_we = 0; bus.dm_addr = '0; bus.dm_wdata = '0; bus.dm_wstrb = '0;
      bus.mem_gnt = 0; bus.mem_rvalid = 0; bus.mem_rdata = '0;
   endtask

   task automatic chk_all_zero(input string pfx);
      chk({pfx, "_if_gnt"},    bus.if_gnt,    0);
      chk({pfx, "_if_rvalid"}, bus.if_rvalid, 0);
      chk({pfx, "_if_rdata"},  bus.if_rdata,  0);
      chk({pfx, "_dm_gnt"},    bus.dm_gnt,    0);
      chk({pfx, "_dm_rvalid"}, bus.dm_rvalid, 0);
      chk({pfx, "_dm_rdata"},  bus.dm_rdata,  0);
      chk({pfx, "_mem_req"},   bus.mem_req,   0);
      chk({pfx, "_mem_we"},    bus.mem_we,    0);
      chk({pfx, "_mem_addr"},  bus.mem_addr,  0);
      chk({pfx, "_mem_wdata"}, bus.mem_wdata, 0);
      chk({pfx, "_mem_wstrb"}, bus.mem_wstrb, 0);
      chk({pfx, "_err_spur"},  bus.err_spur,  0);
   endtask

   // asserts reset from the current point in time, checks outputs clear immediately
   task automatic do_reset(input string pfx);
      rst_n = 1'b0;
      #1;
      chk_all_zero(pfx);
      model_clear();
      drive_idle_inputs();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // advance one cycle and compare every output with the model
   task automatic tick();
      bit p_if, p_dm, p_dwe, p_mg, p_mv, win_if;
      logic [31:0] p_ia, p_da, p_dw, p_mr;
      logic [3:0]  p_ds;
      bit e_ig, e_dg, e_ir, e_dr;
      p_if = bus.if_req; p_ia = bus.if_addr;
      p_dm = bus.dm_req; p_dwe = bus.dm_we; p_da = bus.dm_addr; p_dw = bus.dm_wdata; p_ds = bus.dm_wstrb;
      p_mg = bus.mem_gnt; p_mv = bus.mem_rvalid; p_mr = bus.mem_rdata;
      e_ig = 0; e_dg = 0; e_ir = 0; e_dr = 0;
      @(posedge clk);
      @(negedge clk);
      case (m_phase)
         0: begin
            if (p_mv) exp_err = 1;
            if (p_if || p_dm) begin
               win_if = p_if && (!p_dm || m_streak == MAXS);
               m_phase = 1;
               m_owner_dm = !win_if;
               if (win_if) begin
                  e_ig = 1; m_we = 0; m_addr = p_ia; m_wstrb = '0; m_streak = 0;
               end else begin
                  e_dg = 1; m_we = p_dwe; m_addr = p_da; m_wdata = p_dw;
                  m_wstrb = p_dwe ? p_ds : 4'h0;
                  m_streak = p_if ? ((m_streak < MAXS) ? m_streak + 1 : MAXS) : 0;
               end
            end
         end
         1: begin
            if (p_mv) exp_err = 1;
            if (p_mg) m_phase = 2;
         end
         default: begin
            if (p_mv) begin
               m_phase = 0;
               if (m_owner_dm) begin
                  e_dr = 1; last_dm = m_we ? 32'h0 : p_mr;
               end else begin
                  e_ir = 1; last_if = p_mr;
               end
            end
         end
      endcase
      chk("if_gnt",    bus.if_gnt,    e_ig);
      chk("dm_gnt",    bus.dm_gnt,    e_dg);
      chk("if_rvalid", bus.if_rvalid, e_ir);
      chk("dm_rvalid", bus.dm_rvalid, e_dr);
      chk("if_rdata",  bus.if_rdata,  last_if);
      chk("dm_rdata",  bus.dm_rdata,  last_dm);
      chk("err_spur",  bus.err_spur,  exp_err);
      chk("mem_req",   bus.mem_req,   m_phase == 1);
      if (m_phase == 1) begin
         chk("mem_addr",  bus.mem_addr,  m_addr);
         chk("mem_we",    bus.mem_we,    m_we);
         chk("mem_wstrb", bus.mem_wstrb, m_wstrb);
         if (m_we) chk("mem_wdata", bus.mem_wdata, m_wdata);
      end
   endtask

   // memory environment: random accept delay and response delay
   task automatic drive_mem();
      bus.mem_gnt = 0; bus.mem_rvalid = 0; bus.mem_rdata = $urandom;
      if (r_wait > 0) begin
         r_wait--;
      end else if (r_wait == 0) begin
         bus.mem_rvalid = 1;
         if (!r_we) bus.mem_rdata = mem_model[r_idx];
         r_wait = -1;
      end else if (bus.mem_req && $urandom_range(0, 1) == 1) begin
         bus.mem_gnt = 1;
         r_we  = bus.mem_we;
         r_idx = int'(bus.mem_addr[5:2]);
         for (int b = 0; b < 4; b++)
            if (bus.mem_we && bus.mem_wstrb[b]) mem_model[r_idx][8*b +: 8] = bus.mem_wdata[8*b +: 8];
         r_wait = $urandom_range(0, 2);
      end
   endtask

   // requesters: hold until granted, then maybe issue a fresh request
   task automatic drive_reqs();
      if (bus.if_gnt) bus.if_req = 0;
      if (bus.dm_gnt) bus.dm_req = 0;
      if (!bus.if_req && $urandom_range(0, 2) == 0) begin
         bus.if_req  = 1;
         bus.if_addr = 32'($urandom_range(0, 15)) << 2;
      end
      if (!bus.dm_req && $urandom_range(0, 1) == 0) begin
         bus.dm_req   = 1;
         bus.dm_we    = 1'($urandom_range(0, 1));
         bus.dm_addr  = 32'($urandom_range(0, 15)) << 2;
         bus.dm_wdata = $urandom;
         bus.dm_wstrb = 4'($urandom_range(0, 15));
      end
   endtask

   initial begin
      logic [5:0] seq;
      int n;
      for (int i = 0; i < 16; i++) mem_model[i] = '0;
      drive_idle_inputs();
      model_clear();
      #2;
      do_reset("rst0");

      // 1: lone fetch, memory accepts at once and responds one cycle later
      bus.if_req = 1; bus.if_addr = 32'h100;
      tick();
      chk("t1_if_gnt", bus.if_gnt, 1);
      chk("t1_mem_req", bus.mem_req, 1);
      chk("t1_mem_addr", bus.mem_addr, 32'h100);
      bus.if_req = 0; bus.mem_gnt = 1;
      tick();
      bus.mem_gnt = 0; bus.mem_rvalid = 1; bus.mem_rdata = 32'hDEADBEEF;
      tick();
      chk("t1_if_rvalid", bus.if_rvalid, 1);
      chk("t1_if_rdata", bus.if_rdata, 32'hDEADBEEF);
      bus.mem_rvalid = 0;
      tick();

      // 2: contention, store wins, slow memory accept, fetch follows
      bus.if_req = 1; bus.if_addr = 32'h300;
      bus.dm_req = 1; bus.dm_we = 1; bus.dm_addr = 32'h200; bus.dm_wdata = 32'hCAFE0123; bus.dm_wstrb = 4'hF;
      tick();
      chk("t2_dm_gnt", bus.dm_gnt, 1);
      bus.dm_req = 0;
      repeat (3) begin
         tick();
         chk("t2_hold_addr", bus.mem_addr, 32'h200);
      end
      bus.mem_gnt = 1;
      tick();
      bus.mem_gnt = 0; bus.mem_rvalid = 1; bus.mem_rdata = 32'h12345678;
      tick();
      chk("t2_dm_rvalid", bus.dm_rvalid, 1);
      chk("t2_dm_rdata", bus.dm_rdata, 0);
      bus.mem_rvalid = 0;
      tick();
      chk("t2_if_gnt", bus.if_gnt, 1);
      bus.if_req = 0; bus.mem_gnt = 1;
      tick();
      bus.mem_gnt = 0; bus.mem_rvalid = 1; bus.mem_rdata = 32'h0BADF00D;
      tick();
      bus.mem_rvalid = 0;
      tick();

      // 3: data port hammering while fetch waits
      do_reset("rst3");
      bus.if_req = 1; bus.if_addr = 32'h40;
      bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 32'h8;
      seq = '0; n = 0;
      for (int c = 0; c < 300 && n < 6; c++) begin
         drive_mem();
         tick();
         if (bus.dm_gnt) begin seq[n] = 1'b1; n++; bus.dm_addr = 32'($urandom_range(0, 15)) << 2; end
         if (bus.if_gnt) begin seq[n] = 1'b0; n++; bus.if_req = 0; end
      end
      chk("t3_grants", n, 6);
      chk("t3_order", seq, 6'b101111);
      bus.dm_req = 0;
      repeat (10) begin drive_mem(); tick(); end

      // 4: reset while waiting for the response
      bus.if_req = 1; bus.if_addr = 32'h44;
      tick();
      bus.if_req = 0; bus.mem_gnt = 1;
      tick();
      bus.mem_gnt = 0;
      do_reset("t4_rst");
      bus.mem_rvalid = 1; bus.mem_rdata = 32'hFFFF0000;
      tick();
      chk("t4_err", bus.err_spur, 1);
      bus.mem_rvalid = 0;
      tick();

      // 5: spurious response while idle
      do_reset("rst5");
      bus.mem_rvalid = 1; bus.mem_rdata = 32'h55AA55AA;
      tick();
      chk("t5_err", bus.err_spur, 1);
      bus.mem_rvalid = 0;
      repeat (4) tick();
      chk("t5_err_sticky", bus.err_spur, 1);
      do_reset("t5_rst");

      // random traffic
      repeat (1500) begin
         drive_reqs();
         drive_mem();
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
